// File: rtl/id_stage_pipe.sv
// Registered RV decode stage: decodes OP-IMM/OP/LUI, reads and forwards operands,
// and holds the result in a single-entry ID/EX register with a valid/ready handshake.
module id_stage_pipe #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned RADDR_W = 5,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [31:0]        inst_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic               flush_i,
    output logic [RADDR_W-1:0] reg1_raddr_o,
    output logic [RADDR_W-1:0] reg2_raddr_o,
    output logic               reg1_re_o,
    output logic               reg2_re_o,
    input  logic [XLEN-1:0]    reg1_rdata_i,
    input  logic [XLEN-1:0]    reg2_rdata_i,
    input  logic               ex_we_i,
    input  logic [RADDR_W-1:0] ex_waddr_i,
    input  logic [XLEN-1:0]    ex_wdata_i,
    input  logic               wb_we_i,
    input  logic [RADDR_W-1:0] wb_waddr_i,
    input  logic [XLEN-1:0]    wb_wdata_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [XLEN-1:0]    op1_o,
    output logic [XLEN-1:0]    op2_o,
    output logic [3:0]         alu_op_o,
    output logic               reg_we_o,
    output logic [RADDR_W-1:0] reg_waddr_o,
    output logic               illegal_o
);

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_PASS2 = 4'd10
    } alu_op_e;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    logic [6:0]         opcode;
    logic [2:0]         funct3;
    logic [6:0]         funct7;
    logic [RADDR_W-1:0] rd, rs1, rs2;
    logic [XLEN-1:0]    imm_i, imm_u, imm_sh;
    logic               shamt_hi_ok;

    logic               dec_legal;
    logic               dec_re1, dec_re2;
    alu_op_e            dec_alu;
    logic [XLEN-1:0]    dec_imm;

    logic               accept;
    logic               valid_q, valid_d;
    logic [XLEN-1:0]    op1_q, op1_d, op2_q, op2_d;
    alu_op_e            alu_q, alu_d;
    logic               we_q, we_d;
    logic [RADDR_W-1:0] waddr_q, waddr_d;
    logic               ill_q, ill_d;

    assign opcode = inst_i[6:0];
    assign funct3 = inst_i[14:12];
    assign funct7 = inst_i[31:25];
    assign rd     = RADDR_W'(inst_i[11:7]);
    assign rs1    = RADDR_W'(inst_i[19:15]);
    assign rs2    = RADDR_W'(inst_i[24:20]);
    assign imm_i  = XLEN'($signed(inst_i[31:20]));
    assign imm_u  = XLEN'($signed({inst_i[31:12], 12'b0}));
    assign imm_sh = XLEN'(inst_i[20 +: SHAMT_W]);
    // On RV32 inst[25] is not part of shamt and must be zero.
    assign shamt_hi_ok = (XLEN != 32) || !inst_i[25];

    function automatic logic [XLEN-1:0] fwd(input logic [RADDR_W-1:0] r,
                                            input logic [XLEN-1:0]    rf);
        if (r == '0)                        return '0;
        else if (ex_we_i && ex_waddr_i == r) return ex_wdata_i;
        else if (wb_we_i && wb_waddr_i == r) return wb_wdata_i;
        else                                 return rf;
    endfunction

    always_comb begin
        dec_legal = 1'b0;
        dec_re1   = 1'b0;
        dec_re2   = 1'b0;
        dec_alu   = ALU_ADD;
        dec_imm   = '0;
        unique case (opcode)
            OPC_OP_IMM: begin
                dec_legal = 1'b1;
                dec_re1   = 1'b1;
                dec_imm   = imm_i;
                unique case (funct3)
                    3'b000: dec_alu = ALU_ADD;
                    3'b010: dec_alu = ALU_SLT;
                    3'b011: dec_alu = ALU_SLTU;
                    3'b100: dec_alu = ALU_XOR;
                    3'b110: dec_alu = ALU_OR;
                    3'b111: dec_alu = ALU_AND;
                    3'b001: begin
                        dec_alu   = ALU_SLL;
                        dec_imm   = imm_sh;
                        dec_legal = (inst_i[31:26] == 6'b000000) && shamt_hi_ok;
                    end
                    3'b101: begin
                        dec_alu   = inst_i[30] ? ALU_SRA : ALU_SRL;
                        dec_imm   = imm_sh;
                        dec_legal = ((inst_i[31:26] == 6'b000000) ||
                                     (inst_i[31:26] == 6'b010000)) && shamt_hi_ok;
                    end
                    default: dec_legal = 1'b0;
                endcase
            end
            OPC_OP: begin
                dec_re1 = 1'b1;
                dec_re2 = 1'b1;
                if (funct7 == 7'b0000000) begin
                    dec_legal = 1'b1;
                    unique case (funct3)
                        3'b000: dec_alu = ALU_ADD;
                        3'b001: dec_alu = ALU_SLL;
                        3'b010: dec_alu = ALU_SLT;
                        3'b011: dec_alu = ALU_SLTU;
                        3'b100: dec_alu = ALU_XOR;
                        3'b101: dec_alu = ALU_SRL;
                        3'b110: dec_alu = ALU_OR;
                        3'b111: dec_alu = ALU_AND;
                        default: dec_alu = ALU_ADD;
                    endcase
                end else if (funct7 == 7'b0100000) begin
                    if (funct3 == 3'b000) begin
                        dec_legal = 1'b1;
                        dec_alu   = ALU_SUB;
                    end else if (funct3 == 3'b101) begin
                        dec_legal = 1'b1;
                        dec_alu   = ALU_SRA;
                    end
                end
            end
            OPC_LUI: begin
                dec_legal = 1'b1;
                dec_alu   = ALU_PASS2;
                dec_imm   = imm_u;
            end
            default: dec_legal = 1'b0;
        endcase
    end

    assign reg1_re_o    = in_valid_i && dec_legal && dec_re1;
    assign reg2_re_o    = in_valid_i && dec_legal && dec_re2;
    assign reg1_raddr_o = reg1_re_o ? rs1 : '0;
    assign reg2_raddr_o = reg2_re_o ? rs2 : '0;

    assign in_ready_o = !valid_q || out_ready_i;
    assign accept     = in_valid_i && in_ready_o && !flush_i;

    always_comb begin
        op1_d   = '0;
        op2_d   = '0;
        alu_d   = ALU_ADD;
        we_d    = 1'b0;
        waddr_d = '0;
        ill_d   = 1'b1;
        if (dec_legal) begin
            op1_d   = dec_re1 ? fwd(rs1, reg1_rdata_i) : '0;
            op2_d   = dec_re2 ? fwd(rs2, reg2_rdata_i) : dec_imm;
            alu_d   = dec_alu;
            we_d    = 1'b1;
            waddr_d = rd;
            ill_d   = 1'b0;
        end
    end

    always_comb begin
        valid_d = valid_q;
        if (flush_i)
            valid_d = 1'b0;
        else if (accept)
            valid_d = 1'b1;
        else if (valid_q && out_ready_i)
            valid_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            op1_q   <= '0;
            op2_q   <= '0;
            alu_q   <= ALU_ADD;
            we_q    <= 1'b0;
            waddr_q <= '0;
            ill_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            if (accept) begin
                op1_q   <= op1_d;
                op2_q   <= op2_d;
                alu_q   <= alu_d;
                we_q    <= we_d;
                waddr_q <= waddr_d;
                ill_q   <= ill_d;
            end
        end
    end

    assign out_valid_o = valid_q;
    assign op1_o       = op1_q;
    assign op2_o       = op2_q;
    assign alu_op_o    = alu_q;
    assign reg_we_o    = we_q;
    assign reg_waddr_o = waddr_q;
    assign illegal_o   = ill_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: decode, forwarding, handshake, flush and async reset.
module tb_id_stage_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] inst;
    logic        in_valid, in_ready, flush;
    logic [4:0]  raddr1, raddr2;
    logic        re1, re2;
    logic [31:0] rdata1, rdata2;
    logic        ex_we, wb_we;
    logic [4:0]  ex_waddr, wb_waddr;
    logic [31:0] ex_wdata, wb_wdata;
    logic        out_valid, out_ready;
    logic [31:0] op1, op2;
    logic [3:0]  alu_op;
    logic        we;
    logic [4:0]  waddr;
    logic        ill;

    logic [31:0] regs [32];
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign rdata1 = regs[raddr1];
    assign rdata2 = regs[raddr2];

    id_stage_pipe #(.XLEN(32), .RADDR_W(5), .SHAMT_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .inst_i(inst), .in_valid_i(in_valid), .in_ready_o(in_ready), .flush_i(flush),
        .reg1_raddr_o(raddr1), .reg2_raddr_o(raddr2),
        .reg1_re_o(re1), .reg2_re_o(re2),
        .reg1_rdata_i(rdata1), .reg2_rdata_i(rdata2),
        .ex_we_i(ex_we), .ex_waddr_i(ex_waddr), .ex_wdata_i(ex_wdata),
        .wb_we_i(wb_we), .wb_waddr_i(wb_waddr), .wb_wdata_i(wb_wdata),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .op1_o(op1), .op2_o(op2), .alu_op_o(alu_op),
        .reg_we_o(we), .reg_waddr_o(waddr), .illegal_o(ill)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'h1000 + i;
        regs[2] = 32'd5;
        rst_n = 1'b0; inst = '0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        ex_we = 1'b0; ex_waddr = '0; ex_wdata = '0;
        wb_we = 1'b0; wb_waddr = '0; wb_wdata = '0;

        #2;
        chk("rst_valid", out_valid, 0); chk("rst_op1", op1, 0); chk("rst_op2", op2, 0);
        chk("rst_alu", alu_op, 0); chk("rst_we", we, 0); chk("rst_waddr", waddr, 0);
        chk("rst_ill", ill, 0); chk("rst_in_ready", in_ready, 1);
        #10 rst_n = 1'b1;

        // ADDI x1,x2,-1
        inst = 32'hFFF10093; in_valid = 1'b1; #1;
        chk("addi_raddr1", raddr1, 2); chk("addi_re1", re1, 1);
        chk("addi_re2", re2, 0); chk("addi_raddr2", raddr2, 0);
        tick(); in_valid = 1'b0; #1;
        chk("addi_valid", out_valid, 1); chk("addi_op1", op1, 5);
        chk("addi_op2", op2, 32'hFFFFFFFF); chk("addi_alu", alu_op, 0);
        chk("addi_waddr", waddr, 1); chk("addi_we", we, 1); chk("addi_ill", ill, 0);
        chk("idle_re1", re1, 0); chk("idle_raddr1", raddr1, 0);
        tick();
        chk("consume_valid", out_valid, 0); chk("consume_hold_op1", op1, 5);

        // SRAI x3,x4,7 then SUB x5,x6,x7 back-to-back
        inst = 32'h40725193; in_valid = 1'b1;
        tick(); inst = 32'h407302B3; #1;
        chk("sub_re2", re2, 1); chk("sub_raddr1", raddr1, 6); chk("sub_raddr2", raddr2, 7);
        chk("srai_valid", out_valid, 1); chk("srai_alu", alu_op, 7); chk("srai_op2", op2, 7);
        chk("srai_op1", op1, 32'h1004); chk("srai_waddr", waddr, 3);
        tick(); in_valid = 1'b0;
        chk("sub_valid", out_valid, 1); chk("sub_alu", alu_op, 1); chk("sub_op1", op1, 32'h1006);
        chk("sub_op2", op2, 32'h1007); chk("sub_waddr", waddr, 5); chk("sub_we", we, 1);

        // SLLI x1,x1,3 then SLLI with inst[25]=1 (illegal on RV32)
        inst = 32'h00309093; in_valid = 1'b1;
        tick(); inst = 32'h02309093; #1;
        chk("slli_bad_re1", re1, 0); chk("slli_bad_raddr1", raddr1, 0);
        chk("slli_alu", alu_op, 2); chk("slli_op2", op2, 3); chk("slli_op1", op1, 32'h1001);
        tick(); in_valid = 1'b0;
        chk("ill_valid", out_valid, 1); chk("ill_flag", ill, 1); chk("ill_we", we, 0);
        chk("ill_waddr", waddr, 0); chk("ill_op1", op1, 0); chk("ill_op2", op2, 0);
        chk("ill_alu", alu_op, 0);

        // Forwarding: ADD x8,x9,x9
        ex_we = 1'b1; ex_waddr = 5'd9; ex_wdata = 32'hAA;
        wb_we = 1'b1; wb_waddr = 5'd9; wb_wdata = 32'hBB;
        inst = 32'h00948433; in_valid = 1'b1;
        tick(); ex_we = 1'b0;
        chk("fwd_ex_op1", op1, 32'hAA); chk("fwd_ex_op2", op2, 32'hAA); chk("fwd_add_alu", alu_op, 0);
        tick();
        chk("fwd_wb_op1", op1, 32'hBB); chk("fwd_wb_op2", op2, 32'hBB);
        inst = 32'h00900433; ex_we = 1'b1; ex_waddr = 5'd0; wb_we = 1'b0;
        tick(); in_valid = 1'b0;
        chk("fwd_x0_op1", op1, 0); chk("fwd_x0_op2", op2, 32'h1009); chk("fwd_x0_waddr", waddr, 8);
        ex_we = 1'b0;
        tick();
        chk("fwd_drain_valid", out_valid, 0);

        // Backpressure: hold ADDI for 3 cycles while SLLI waits
        inst = 32'hFFF10093; in_valid = 1'b1; out_ready = 1'b1;
        tick(); out_ready = 1'b0; inst = 32'h00309093;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_in_ready", in_ready, 0); chk("bp_valid", out_valid, 1);
            chk("bp_alu", alu_op, 0); chk("bp_op1", op1, 5);
            tick();
        end
        chk("bp_frozen_op2", op2, 32'hFFFFFFFF); chk("bp_frozen_valid", out_valid, 1);
        out_ready = 1'b1; #1;
        chk("bp_release_ready", in_ready, 1);
        tick(); in_valid = 1'b0;
        chk("bp_next_valid", out_valid, 1); chk("bp_next_alu", alu_op, 2); chk("bp_next_op2", op2, 3);
        tick();
        chk("bp_no_dup", out_valid, 0);

        // Flush with a held entry and a simultaneous offer
        inst = 32'h407302B3; in_valid = 1'b1;
        tick(); out_ready = 1'b0; inst = 32'h40725193; flush = 1'b1;
        tick(); flush = 1'b0; in_valid = 1'b0; #1;
        chk("flush_valid", out_valid, 0);
        out_ready = 1'b1;
        tick();
        chk("flush_no_appear", out_valid, 0);

        // Asynchronous reset mid-stream, then LUI x10,0x12345
        inst = 32'hFFF10093; in_valid = 1'b1;
        tick(); in_valid = 1'b0; #1;
        chk("pre_rst_valid", out_valid, 1);
        rst_n = 1'b0; #1;
        chk("arst_valid", out_valid, 0); chk("arst_op1", op1, 0); chk("arst_op2", op2, 0);
        chk("arst_alu", alu_op, 0); chk("arst_we", we, 0); chk("arst_waddr", waddr, 0);
        chk("arst_ill", ill, 0);
        #1 rst_n = 1'b1;
        inst = 32'h12345537; in_valid = 1'b1; #1;
        chk("lui_re1", re1, 0); chk("lui_re2", re2, 0);
        tick(); in_valid = 1'b0;
        chk("lui_valid", out_valid, 1); chk("lui_op2", op2, 32'h12345000);
        chk("lui_alu", alu_op, 10); chk("lui_waddr", waddr, 10);
        chk("lui_op1", op1, 0); chk("lui_we", we, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
- Registered, parametrised decode stage for the RV core; successor to the purely combinational I-type decoder.
- Decodes OP-IMM (all I-type ALU ops incl. shifts), OP (R-type ALU) and LUI.
- Reads the register file combinationally and forwards from EX/WB.
- Captures operands, control and illegal flag into a single-entry ID/EX register with valid/ready handshake, stall and flush.

Parameters:
- XLEN, 32, datapath/operand width (32 or 64).
- RADDR_W, 5, register address width.
- SHAMT_W, 5, shift-amount width; 5 when XLEN=32, 6 when XLEN=64.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- inst_i  in  32  instruction from IF.
- in_valid_i  in  1  inst_i valid.
- in_ready_o  out  1  stage can accept inst_i this cycle.
- flush_i  in  1  kill held entry and any same-cycle accept.
- reg1_raddr_o / reg2_raddr_o  out  RADDR_W  regfile read addresses (combinational).
- reg1_re_o / reg2_re_o  out  1  regfile read enables (combinational).
- reg1_rdata_i / reg2_rdata_i  in  XLEN  regfile read data.
- ex_we_i, ex_waddr_i, ex_wdata_i  in  1/RADDR_W/XLEN  EX-stage result for forwarding.
- wb_we_i, wb_waddr_i, wb_wdata_i  in  1/RADDR_W/XLEN  WB-stage result for forwarding.
- out_valid_o  out  1  ID/EX entry valid.
- out_ready_i  in  1  EX accepts entry.
- op1_o, op2_o  out  XLEN  registered operands.
- alu_op_o  out  4  registered ALU op.
- reg_we_o  out  1  registered write enable.
- reg_waddr_o  out  RADDR_W  registered rd.
- illegal_o  out  1  registered illegal-instruction flag.

Behaviour:
- Handshake:
  - in_ready_o = !out_valid_o || out_ready_i.
  - Accept when in_valid_i && in_ready_o && !flush_i; the register loads next edge and out_valid_o=1.
  - Entry consumed when out_valid_o && out_ready_i. If no new accept, out_valid_o falls to 0 and payload holds.
  - Held entry is stable while out_valid_o && !out_ready_i.
- Flush: out_valid_o=0 next edge; same-cycle accept is discarded; payload regs are don't-care.
- Reset (async, rst_n=0): out_valid_o=0, op1_o=op2_o=0, alu_op_o=0, reg_we_o=0, reg_waddr_o=0, illegal_o=0. Mid-operation reset drops the held entry immediately.
- Latency: 1 cycle from accept to out_valid_o.
- alu_op encoding: ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9, PASS2=10.
- Decode by opcode inst_i[6:0]:
  - OP-IMM 0010011: re1=1, re2=0, raddr1=rs1, raddr2=0.
    - op1 = fwd(rs1).
    - op2 = sign-extend of inst[31:20] to XLEN, except shifts.
    - Shifts: op2 = zero-extended inst[20+SHAMT_W-1:20].
    - SLLI requires inst[31:26]=0; SRLI/SRAI require inst[31:26] = 000000 / 010000.
    - XLEN=32 additionally requires inst[25]=0. Violations are illegal.
  - OP 0110011: re1=re2=1, op1=fwd(rs1), op2=fwd(rs2).
    - funct7 0000000 selects the base op; 0100000 is legal only for ADD→SUB and SRL→SRA. Anything else is illegal.
  - LUI 0110111: re1=re2=0, op1=0, op2 = sign-extend of {inst[31:12],12'b0}, alu_op=PASS2.
  - Other opcodes: illegal.
- Illegal entries: illegal_o=1, reg_we_o=0, reg_waddr_o=0, op1/op2=0, alu_op=ADD. Both read enables 0, both addresses 0.
- Legal entries: reg_we_o=1, reg_waddr_o=rd; rd=0 is still legal with reg_we_o=1 (writes to x0 are discarded downstream).
- Read addresses and enables are driven combinationally whenever in_valid_i=1. When in_valid_i=0 they are 0/0.
- fwd(r):
  - r==0 gives 0.
  - Otherwise use EX data if ex_we_i && ex_waddr_i==r, else WB data if wb_we_i && wb_waddr_i==r, else regfile data.
  - EX has priority over WB when both match.
- All arithmetic is XLEN-wide; no truncation of sign extension.

Test Plan:
- ADDI x1,x2,-1 (0xFFF10093), x2 reg=5, no forwarding → next cycle out_valid=1, op1=5, op2=0xFFFFFFFF, alu_op=0, waddr=1, we=1, illegal=0.
- SRAI x3,x4,7 (0x40725193) and SUB x5,x6,x7 (0x407302B3) → alu_op 7 with op2=7; then alu_op 1 with op2=rs2 data. SLLI with inst[25]=1 at XLEN=32 → illegal_o=1, we=0.
- Forwarding: ADD x8,x9,x9 with ex_waddr=9 data 0xAA and wb_waddr=9 data 0xBB → op1=op2=0xAA. With ex_we=0 → 0xBB. With rs1=x0 and ex_waddr=0 → op1=0.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 → in_ready=0, outputs frozen. Raise out_ready → next instruction appears the following cycle, none lost or duplicated.
- Flush with simultaneous in_valid and a held entry → out_valid=0 next cycle; the flushed instruction never appears.
- Assert rst_n=0 mid-stream → all outputs 0 immediately (asynchronous). After release, first accept appears 1 cycle later. LUI x10,0x12345 → op2=0x12345000, alu_op=10.
